arb_pkt_mux: RTL and testbench
==============================

ARB_PKT_MUX -- requirements
Module: arb_pkt_mux

Interface
REQ-001 Parameter N, default 4, number of requester ports (N >= 2).
REQ-002 Parameter DW, default 32, data width per beat.
REQ-003 Parameter CW, default 16, completed-packet counter width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  N  per-port beat valid.
REQ-007 in_ready  output  N  per-port beat accept.
REQ-008 in_data  input  N*DW  per-port data; port i occupies bits [i*DW +: DW].
REQ-009 in_last  input  N  per-port last beat of packet.
REQ-010 arb_req  output  N  request vector driven to the round-robin arbiter.
REQ-011 arb_grant  input  N  registered one-hot grant returned by the arbiter.
REQ-012 out_valid, out_ready, out_data[DW], out_last  output/input/output/output  merged packet stream.
REQ-013 out_src  output  $clog2(N)  index of the port owning the current packet.
REQ-014 pkt_cnt  output  CW  count of completed packets.

Function
REQ-015 The FSM SHALL have states IDLE, XFER, RELEASE.
REQ-016 In IDLE: when arb_grant is one-hot and in_valid at that bit is 1, the module SHALL latch the port index into owner and enter XFER next cycle; otherwise it SHALL remain in IDLE.
REQ-017 In XFER: out_valid=in_valid[owner], out_data=in_data[owner], out_last=in_last[owner], in_ready[owner]=out_ready, combinationally (zero latency).
REQ-018 In XFER: in_ready of every non-owner port SHALL be 0.
REQ-019 A beat with out_valid & out_ready & out_last SHALL move the FSM to RELEASE and increment pkt_cnt by 1, modulo 2^CW.
REQ-020 Outside XFER: out_valid=0, out_last=0, out_data=0, all in_ready=0; out_src SHALL hold owner.
REQ-021 arb_req SHALL equal in_valid, except that in RELEASE arb_req[owner] SHALL be forced to 0.
REQ-022 In RELEASE: once arb_grant[owner]==0, the FSM SHALL return to IDLE next cycle; otherwise it SHALL remain in RELEASE.
REQ-023 First beat of a packet SHALL be offered on out_* one cycle after the grant is observed in IDLE.
REQ-024 Single-beat packet (in_last=1 on first beat) SHALL go XFER->RELEASE after one handshake.
REQ-025 Back-to-back packets from the same port SHALL be separated by at least one RELEASE cycle.
REQ-026 arb_grant changes while in XFER SHALL be ignored; ownership ends only on the last beat.

Reset
REQ-027 On rst_n low, the module SHALL asynchronously enter IDLE with owner=0, pkt_cnt=0, out_src=0, and all in_ready and out_* outputs at 0, including mid-packet.
REQ-028 After reset release, the first grant SHALL be processed per REQ-016.

Configuration
REQ-029 Macro ARB_PKT_MUX_GRANT_CHECK_EN SHALL control grant checking.
REQ-030 With the macro defined: output grant_err (1 bit) SHALL be set when arb_grant is non-zero and not one-hot in any state, or non-zero with in_valid at that bit 0 in IDLE; it SHALL be sticky until reset.
REQ-031 Without the macro: grant_err does not exist, and malformed grants SHALL be ignored per REQ-016.

Structure
REQ-032 A shared package arb_pkt_mux_pkg SHALL hold the FSM state enum (IDLE, XFER, RELEASE) and the one-hot-to-index function.
REQ-033 Sub-module arb_pkt_mux_onehot_enc (one-hot to index plus is-one-hot flag) SHALL perform the grant decoding.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Port 2 sends a 3-beat packet, arb_grant=0100, out_ready=1 -> out_src=2, three beats out starting the cycle after grant, pkt_cnt=1, arb_req[2]=0 in RELEASE.
- Ports 0 and 1 both valid with 2-beat packets, arbiter in loop -> packets emitted as port 0 then port 1, no interleaving, pkt_cnt=2.
- out_ready held 0 for 5 cycles mid-packet -> beat held stable, in_ready[owner]=0, no FSM change.
- Reset asserted during beat 2 of a 4-beat packet -> all outputs 0 immediately, FSM IDLE, pkt_cnt=0.
- With CW=2, five single-beat packets -> pkt_cnt wraps to 1.
- With the macro defined, arb_grant=0011 -> grant_err=1 and held; FSM stays IDLE.

Source files
------------

// File: rtl/arb_pkt_mux_pkg.sv
// arb_pkt_mux shared types: FSM state encoding
// and one-hot to index helper.
package arb_pkt_mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int unsigned MAX_N = 32;
  localparam int unsigned MAX_IW = 5;

  // Ports wider than MAX_N are not supported.
  function automatic logic [MAX_IW-1:0] oh_to_idx(
    input logic [MAX_N-1:0] oh
  );
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx |= MAX_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pkt_mux_onehot_enc.sv
// Grant decoder: one-hot vector to port index
// plus a flag telling whether exactly one bit is set.
import arb_pkt_mux_pkg::*;

module arb_pkt_mux_onehot_enc #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          onehot
);

  logic [MAX_N-1:0] wide;

  assign wide = MAX_N'(vec);
  assign idx = IW'(oh_to_idx(wide));

  // Clearing the lowest set bit leaves zero only for one-hot.
  assign onehot = (vec != '0) &&
                  ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/arb_pkt_mux.sv
// Packet mux driven by an external round-robin arbiter.
// ARB_PKT_MUX_GRANT_CHECK_EN adds a sticky grant_err output.
import arb_pkt_mux_pkg::*;

module arb_pkt_mux #(
  parameter int N = 4,
  parameter int DW = 32,
  parameter int CW = 16,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]  in_last,
  output logic [N-1:0]  arb_req,
  input  logic [N-1:0]  arb_grant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [IW-1:0] out_src,
  output logic [CW-1:0] pkt_cnt
`ifdef ARB_PKT_MUX_GRANT_CHECK_EN
  ,
  output logic          grant_err
`endif
);

  state_t        state;
  logic [IW-1:0] owner;
  logic [CW-1:0] cnt;
  logic [IW-1:0] g_idx;
  logic          g_oh;
  logic          in_idle;
  logic          in_xfer;
  logic          in_rel;
  logic          start;
  logic          pkt_end;
  logic          rel_done;

  arb_pkt_mux_onehot_enc #(
    .N(N)
  ) u_enc (
    .vec   (arb_grant),
    .idx   (g_idx),
    .onehot(g_oh)
  );

  assign in_idle = (state == IDLE);
  assign in_xfer = (state == XFER);
  assign in_rel  = (state == RELEASE);

  assign start = in_idle && g_oh &&
                 ((in_valid & arb_grant) != '0);

  assign pkt_end = in_xfer && out_valid &&
                   out_ready && out_last;

  // Grant movement is only honoured once the packet is done.
  assign rel_done = in_rel && !arb_grant[owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      unique case (1'b1)
        in_idle: begin
          if (start) begin
            owner <= g_idx;
            state <= XFER;
          end
        end
        in_xfer: begin
          if (pkt_end) state <= RELEASE;
        end
        in_rel: begin
          if (rel_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (pkt_end) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (in_xfer) begin
      out_valid       = in_valid[owner];
      out_data        = in_data[owner*DW +: DW];
      out_last        = in_last[owner];
      in_ready[owner] = out_ready;
    end
  end

  // Masking the owner lets the arbiter move on.
  always_comb begin
    arb_req = in_valid;
    if (in_rel) arb_req[owner] = 1'b0;
  end

  assign out_src = owner;
  assign pkt_cnt = cnt;

`ifdef ARB_PKT_MUX_GRANT_CHECK_EN
  logic bad_grant;

  assign bad_grant =
    ((arb_grant != '0) && !g_oh) ||
    (in_idle && g_oh &&
     ((in_valid & arb_grant) == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_err <= 1'b0;
    end else if (bad_grant) begin
      grant_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Scoreboard bench for arb_pkt_mux with a
// round-robin arbiter model and per-port sources.
module tb_arb_pkt_mux;

  localparam int N = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    arb_grant;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [1:0]      out_src;
  logic [CW-1:0]   pkt_cnt;
`ifdef ARB_PKT_MUX_GRANT_CHECK_EN
  logic            grant_err;
`endif

  logic            auto_arb;
  logic [N-1:0]    man_grant;
  logic [N-1:0]    rr_grant;
  int              rr_last;
  logic [N-1:0]    fire;

  beat_t pq[N][$];
  exp_t  exp_q[$];
  int    seen;
  int    n_pass;
  int    n_total;

  always #5 clk = ~clk;

  arb_pkt_mux #(
    .N (N),
    .DW(DW),
    .CW(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .arb_req  (arb_req),
    .arb_grant(arb_grant),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_src  (out_src),
    .pkt_cnt  (pkt_cnt)
`ifdef ARB_PKT_MUX_GRANT_CHECK_EN
    ,
    .grant_err(grant_err)
`endif
  );

  assign arb_grant = auto_arb ? rr_grant : man_grant;

  function automatic int rr_pick(
    input logic [N-1:0] req,
    input int last
  );
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Registered round-robin arbiter: holds while requested.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_grant <= '0;
      rr_last  <= N - 1;
    end else if ((arb_req & rr_grant) == '0) begin
      if (rr_pick(arb_req, rr_last) >= 0) begin
        rr_grant <= N'(1) << rr_pick(arb_req, rr_last);
        rr_last  <= rr_pick(arb_req, rr_last);
      end else begin
        rr_grant <= '0;
      end
    end
  end

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h",
                  nm, act, req);
  endtask

  // Sources: pop on handshake, present queue head.
  initial begin
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    fire     = '0;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && pq[i].size() > 0)
          void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
          in_valid[i]           = 1'b1;
          in_data[i*DW +: DW]   = pq[i][0].data;
          in_last[i]            = pq[i][0].last;
        end else begin
          in_valid[i]           = 1'b0;
          in_data[i*DW +: DW]   = '0;
          in_last[i]            = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted output beat is checked in order.
  initial begin
    exp_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(out_data), 64'(e.data));
          chk("beat_last", 64'(out_last), 64'(e.last));
          chk("beat_src", 64'(out_src), 64'(e.src));
        end
        seen++;
      end
    end
  end

  task automatic send_pkt(
    input int port,
    input int nb,
    input logic [DW-1:0] base
  );
    beat_t b;
    exp_t  e;
    for (int k = 0; k < nb; k++) begin
      b.data = base + DW'(k);
      b.last = (k == nb - 1);
      e.src  = port;
      e.data = b.data;
      e.last = b.last;
      pq[port].push_back(b);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_seen(
    input string nm,
    input int target
  );
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (seen >= target) break;
    end
    chk(nm, 64'(seen >= target), 64'd1);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    auto_arb  = 1'b0;
    man_grant = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    do_reset();

    // Port 2, manual grant, 3 beats then a 1-beat follow-up.
    send_pkt(2, 3, 32'hA200_0000);
    send_pkt(2, 1, 32'hA2F0_0000);
    repeat (2) @(posedge clk);
    #1;
    man_grant = 4'b0100;
    @(negedge clk);
    chk("s1_idle_no_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("s1_first_valid", 64'(out_valid), 64'd1);
    chk("s1_src", 64'(out_src), 64'd2);
    repeat (3) @(negedge clk);
    chk("s1_rel_valid", 64'(out_valid), 64'd0);
    chk("s1_rel_in_valid", 64'(in_valid), 64'b0100);
    chk("s1_rel_req", 64'(arb_req), 64'b0000);
    chk("s1_cnt", 64'(pkt_cnt), 64'd1);
    @(negedge clk);
    chk("s1_rel_hold", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    man_grant = 4'b0000;
    @(posedge clk);
    #1;
    man_grant = 4'b0100;
    wait_drain("s1_drain");
    @(posedge clk);
    #1;
    man_grant = 4'b0000;
    repeat (2) @(posedge clk);
    chk("s1_cnt2", 64'(pkt_cnt), 64'd2);

    // Ports 0 and 1 compete under the arbiter model.
    do_reset();
    auto_arb = 1'b1;
    send_pkt(0, 2, 32'hB000_0000);
    send_pkt(1, 2, 32'hB100_0000);
    wait_drain("s2_drain");
    repeat (2) @(posedge clk);
    chk("s2_cnt", 64'(pkt_cnt), 64'd2);

    // Back-pressure mid-packet on port 3.
    do_reset();
    send_pkt(3, 3, 32'hC300_0000);
    wait_seen("s3_beat1", seen + 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("s3_hold_valid", 64'(out_valid), 64'd1);
      chk("s3_hold_data", 64'(out_data),
          64'(32'hC300_0001));
      chk("s3_hold_src", 64'(out_src), 64'd3);
      chk("s3_hold_rdy", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("s3_drain");
    repeat (2) @(posedge clk);
    chk("s3_cnt", 64'(pkt_cnt), 64'd1);

    // Reset during beat 2 of a 4-beat packet.
    do_reset();
    send_pkt(0, 4, 32'hD000_0000);
    wait_seen("s4_beat1", seen + 1);
    #1;
    chk("s4_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("s4_valid", 64'(out_valid), 64'd0);
    chk("s4_data", 64'(out_data), 64'd0);
    chk("s4_last", 64'(out_last), 64'd0);
    chk("s4_in_ready", 64'(in_ready), 64'd0);
    chk("s4_cnt", 64'(pkt_cnt), 64'd0);
    chk("s4_src", 64'(out_src), 64'd0);
    do_reset();
    repeat (2) @(negedge clk);
    chk("s4_idle", 64'(out_valid), 64'd0);
    send_pkt(1, 1, 32'hD100_0000);
    wait_drain("s4_drain");
    repeat (2) @(posedge clk);
    chk("s4_cnt_after", 64'(pkt_cnt), 64'd1);

    // Five single-beat packets wrap a 2-bit counter.
    do_reset();
    for (int p = 0; p < 5; p++)
      send_pkt(1, 1, 32'hE100_0000 + DW'(p << 8));
    wait_drain("s5_drain");
    repeat (2) @(posedge clk);
    chk("s5_wrap", 64'(pkt_cnt), 64'd1);

`ifdef ARB_PKT_MUX_GRANT_CHECK_EN
    do_reset();
    auto_arb  = 1'b0;
    man_grant = 4'b0011;
    repeat (2) @(negedge clk);
    chk("s6_err", 64'(grant_err), 64'd1);
    chk("s6_idle", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    man_grant = 4'b0000;
    repeat (3) @(negedge clk);
    chk("s6_err_sticky", 64'(grant_err), 64'd1);
    chk("s6_idle2", 64'(out_valid), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
